alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Adds the RV32M multiply/divide ops, executed iteratively over several cycles.
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid.
- Base ops retire in 1 cycle; MUL*/DIV*/REM* retire after DATA_WIDTH iteration cycles.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two, >= 8.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount bits taken from b (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of any in-flight or held op.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  5  operation code, see Behaviour.
- a  in  DATA_WIDTH  operand A (rs1).
- b  in  DATA_WIDTH  operand B (rs2/imm).
- out_valid  out  1  result held on out.
- out_ready  in  1  consumer takes result.
- out  out  DATA_WIDTH  registered result.
- zero  out  1  registered, equals (out == 0).
- busy  out  1  high in BUSY state.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18-31 behave as ADD.
- Shifts use b[SHAMT_W-1:0]. SLT/SLTU return 0 or 1, zero-extended.
- FSM states: IDLE, BUSY, DONE.
- Reset values: state=IDLE, out=0, zero=1, out_valid=0, busy=0, iteration counter=0.
- IDLE:
  - in_ready=1.
  - Accept occurs on an edge with in_valid=1.
  - Base op: result registered at the accept edge, go to DONE. out_valid is high in the cycle after accept (latency 1).
  - MUL*:
    - Latch operands as magnitudes plus sign flags. MULH signs both operands, MULHSU signs a only, MULHU and MUL sign neither.
    - Go to BUSY. Run a shift-add over a 2*DATA_WIDTH product register, 1 bit per cycle, for DATA_WIDTH cycles.
    - Final step negates the product if the sign flags differ. MUL returns the low half; the others return the high half.
  - DIV*/REM*:
    - Restoring radix-2 on magnitudes, DATA_WIDTH cycles.
    - Quotient sign = sa^sb. Remainder sign = sign of dividend.
  - Iterative latency: out_valid rises exactly DATA_WIDTH+1 cycles after the accept edge. The sign fixup is folded into the last BUSY cycle.
- Div special cases (no BUSY; latency 1):
  - b==0: DIV/DIVU gives all ones; REM/REMU gives a.
  - Signed overflow, DIV/REM only (a = most-negative, b = -1): DIV gives a; REM gives 0.
- BUSY:
  - in_ready=0, busy=1.
  - Counter decrements each cycle; leave BUSY when it reaches 0.
  - in_valid is ignored.
- DONE:
  - out_valid=1. out and zero stay stable while out_ready=0.
  - out_ready=1: go to IDLE next cycle, out_valid=0.
  - No accept is possible in DONE: throughput is at most 1 op per 2 cycles.
- Flush:
  - Any state goes to IDLE on the next edge. out_valid=0, counter cleared, out not required to clear.
  - Flush wins over a simultaneous accept or out_ready.
- rst asserted mid-operation: immediate return to the reset values.
- All arithmetic wraps modulo 2^DATA_WIDTH. No X may reach out for any op/operand combination.

Decomposition:
- Shared package alu_pkg holds:
  - op enum (5-bit ALU_ADD..ALU_REMU, values as listed);
  - FSM state enum;
  - helper function is_muldiv(op).
- One sub-module, mdu_iter: the iterative multiply/divide datapath. It owns the product/remainder registers, counter and sign fixup, with start/done signals toward the alu_mdu FSM.
- Base-op combinational logic stays in alu_mdu.

Test Plan:
- Reset mid-BUSY: MUL accepted, rst pulsed at cycle 5 -> out_valid=0, in_ready=1, out=0, zero=1 immediately.
- Base ops: ADD 0xFFFFFFFF+1 -> out=0, zero=1, latency 1. SRA 0x80000000 by 31 -> 0xFFFFFFFF. SLT -1<1 -> 1. SLTU -1<1 -> 0.
- MUL family:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MUL -7*3 -> 0xFFFFFFEB.
  - out_valid exactly 33 cycles after accept.
- DIV family:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5 (latency 1).
  - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Backpressure: out_ready held 0 for 10 cycles after DIVU completes -> out stable, in_ready=0. Release -> IDLE, next op accepted the following cycle.
- Flush in BUSY at cycle 10, and flush coincident with out_ready in DONE -> IDLE next edge, no out_valid pulse. Subsequent ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op-class helpers for alu_mdu.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_XOR    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_AND    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op >= OP_W'(ALU_MUL)) && (op <= OP_W'(ALU_REMU));
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op >= OP_W'(ALU_DIV)) && (op <= OP_W'(ALU_REMU));
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide step per cycle.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic [OP_W-1:0]       op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  last_c,
  output logic [DATA_WIDTH-1:0] result_c
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  logic [2*DW-1:0]  acc;
  logic [2*DW-1:0]  acc_next;
  logic [2*DW-1:0]  prod_fix;
  logic [DW-1:0]    opnd;
  logic [CNT_W-1:0] cnt;
  logic             is_mul, want_hi, is_rem, neg_res;
  logic             sa, sb;
  logic [DW-1:0]    mag_a, mag_b;
  logic [DW:0]      mul_sum, rem_sh;
  logic [DW-1:0]    rem_new, div_sel;
  logic             ge;

  // Operand signedness per op; magnitudes feed the unsigned iteration
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (op)
      OP_W'(ALU_MULH), OP_W'(ALU_DIV), OP_W'(ALU_REM): begin
        sa = a[DW-1];
        sb = b[DW-1];
      end
      OP_W'(ALU_MULHSU): sa = a[DW-1];
      default: ;
    endcase
  end

  assign mag_a = sa ? DW'(-a) : a;
  assign mag_b = sb ? DW'(-b) : b;

  // Multiplier/dividend sit in acc low half, multiplicand/divisor in opnd
  always_comb begin
    mul_sum  = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc[2*DW-1:DW], acc[DW-1]};
    ge       = rem_sh >= {1'b0, opnd};
    rem_new  = DW'(rem_sh - (ge ? {1'b0, opnd} : '0));
    acc_next = is_mul ? {mul_sum, acc[DW-1:1]} : {rem_new, acc[DW-2:0], ge};
  end

  // Sign fixup applied to the value produced by the final step
  always_comb begin
    prod_fix = neg_res ? (2*DW)'(-acc_next) : acc_next;
    div_sel  = is_rem ? acc_next[2*DW-1:DW] : acc_next[DW-1:0];
    if (is_mul) begin
      result_c = want_hi ? prod_fix[2*DW-1:DW] : prod_fix[DW-1:0];
    end else begin
      result_c = neg_res ? DW'(-div_sel) : div_sel;
    end
  end

  assign last_c = (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      is_mul  <= 1'b0;
      want_hi <= 1'b0;
      is_rem  <= 1'b0;
      neg_res <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (start) begin
      acc     <= {{DW{1'b0}}, is_div(op) ? mag_a : mag_b};
      opnd    <= is_div(op) ? mag_b : mag_a;
      cnt     <= CNT_W'(DATA_WIDTH);
      is_mul  <= !is_div(op);
      want_hi <= (op != OP_W'(ALU_MUL));
      is_rem  <= (op == OP_W'(ALU_REM)) || (op == OP_W'(ALU_REMU));
      neg_res <= (op == OP_W'(ALU_REM)) ? sa : (sa ^ sb);
    end else if (cnt != '0) begin
      acc <= acc_next;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked execute-stage ALU with iterative RV32M multiply/divide.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  zero,
  output logic                  busy
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                state;
  logic [SHAMT_W-1:0]    shamt;
  logic                  div_zero, div_ovf, use_iter, start;
  logic                  mdu_last_c;
  logic [DATA_WIDTH-1:0] base_res_c, mdu_res_c;

  assign shamt    = b[SHAMT_W-1:0];
  assign div_zero = is_div(op) && (b == '0);
  assign div_ovf  = ((op == OP_W'(ALU_DIV)) || (op == OP_W'(ALU_REM))) &&
                    (a == MOST_NEG) && (b == '1);
  assign use_iter = is_muldiv(op) && !div_zero && !div_ovf;
  assign start    = (state == ST_IDLE) && in_valid && use_iter && !flush;

  // Single-cycle results, including the divide corner cases that skip iteration
  always_comb begin
    base_res_c = a + b;
    case (op)
      OP_W'(ALU_SUB):  base_res_c = a - b;
      OP_W'(ALU_XOR):  base_res_c = a ^ b;
      OP_W'(ALU_OR):   base_res_c = a | b;
      OP_W'(ALU_AND):  base_res_c = a & b;
      OP_W'(ALU_SLL):  base_res_c = a << shamt;
      OP_W'(ALU_SRL):  base_res_c = a >> shamt;
      OP_W'(ALU_SRA):  base_res_c = DATA_WIDTH'($signed(a) >>> shamt);
      OP_W'(ALU_SLT):  base_res_c = DATA_WIDTH'($signed(a) < $signed(b));
      OP_W'(ALU_SLTU): base_res_c = DATA_WIDTH'(a < b);
      OP_W'(ALU_DIV), OP_W'(ALU_DIVU): base_res_c = div_zero ? '1 : a;
      OP_W'(ALU_REM), OP_W'(ALU_REMU): base_res_c = div_zero ? a : '0;
      default: ;
    endcase
  end

  mdu_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mdu_iter (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .last_c   (mdu_last_c),
    .result_c (mdu_res_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out       <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (use_iter) begin
              state <= ST_BUSY;
              busy  <= 1'b1;
            end else begin
              state     <= ST_DONE;
              out       <= base_res_c;
              zero      <= (base_res_c == '0);
              out_valid <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (mdu_last_c) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            out       <= mdu_res_c;
            zero      <= (mdu_res_c == '0);
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_alu_mdu;

  localparam int unsigned DW = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [4:0]  op;
  logic [31:0] a, b, out;
  logic        rdy_dir, rdy_rnd, rand_mode;

  typedef struct {
    logic [31:0] val;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   held;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  alu_mdu #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdy_rnd <= ($urandom_range(0, 3) != 0);
  assign out_ready = rand_mode ? rdy_rnd : rdy_dir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Architectural result of each op, from RV32 semantics with 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = 64'(x);
    longint unsigned uy = 64'(y);
    longint          p;
    longint unsigned up;
    logic            ovf = (x == MIN_NEG) && (y == 32'hFFFF_FFFF);
    case (o)
      5'd1:  return x - y;
      5'd2:  return x ^ y;
      5'd3:  return x | y;
      5'd4:  return x & y;
      5'd5:  return x << y[4:0];
      5'd6:  return x >> y[4:0];
      5'd7:  return 32'(sx >>> y[4:0]);
      5'd8:  return (sx < sy) ? 32'd1 : 32'd0;
      5'd9:  return (x < y) ? 32'd1 : 32'd0;
      5'd10: return 32'(sx * sy);
      5'd11: begin p = sx * sy; return p[63:32]; end
      5'd12: begin p = sx * longint'(uy); return p[63:32]; end
      5'd13: begin up = ux * uy; return up[63:32]; end
      5'd14: return (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(sx / sy));
      5'd15: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd16: return (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
      5'd17: return (y == 0) ? x : x % y;
      default: return x + y;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
    if (o < 5'd10 || o > 5'd17) return 1;
    if (o >= 5'd14 && y == 0) return 1;
    if ((o == 5'd14 || o == 5'd16) && x == MIN_NEG && y == 32'hFFFF_FFFF) return 1;
    return DW + 1;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accept edge
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push);
    int   n = 0;
    exp_t e;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout_in_ready", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1; op = o; a = x; b = y;
    if (push) begin
      e.val = ref_model(o, x, y);
      e.acc = cyc + 1;
      e.lat = ref_latency(o, x, y);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  // Monitor: pops on each new result, then holds it while out_valid stays high
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (out_valid) begin
      if (!held) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          cur  = exp_q.pop_front();
          held = 1'b1;
          chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
        end
      end
      if (held) begin
        chk("out", out, cur.val);
        chk("zero", {31'd0, zero}, {31'd0, cur.val == 32'd0});
      end
      if (out_ready) held = 1'b0;
    end else begin
      held = 1'b0;
    end
  end

  localparam int N_DIR = 23;
  logic [4:0]  d_op [N_DIR] = '{5'd0, 5'd7, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd10,
                                5'd14, 5'd16, 5'd15, 5'd17, 5'd14, 5'd16, 5'd14, 5'd16,
                                5'd25, 5'd2, 5'd3, 5'd4, 5'd5, 5'd1, 5'd6};
  logic [31:0] d_a  [N_DIR] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                                32'd3, 32'hF0F0_1234, 32'h0F00_0001, 32'hFF00_FF00,
                                32'h0000_0003, 32'd10, 32'h0000_00F0};
  logic [31:0] d_b  [N_DIR] = '{32'd1, 32'd31, 32'd1, 32'd1,
                                32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3,
                                32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd4, 32'h0F0F_4321, 32'h00F0_0010, 32'h0FF0_0FF0,
                                32'h0000_0024, 32'd3, 32'd4};

  logic [31:0] pool [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 5'd0; a = '0; b = '0;
    rdy_dir = 1'b1; rand_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out", out, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < N_DIR; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1);
    wait_valid();
    @(posedge clk); #1;

    // Reset mid-BUSY, five cycles after a MUL is accepted
    issue(5'd10, 32'd123, 32'd456, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out", out, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Backpressure after DIVU
    rdy_dir = 1'b0;
    issue(5'd15, 32'd100, 32'd7, 1'b1);
    wait_valid();
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    rdy_dir = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    issue(5'd0, 32'd2, 32'd2, 1'b1);
    chk("next_accept", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Flush in BUSY at cycle 10 after accept
    issue(5'd10, 32'd5, 32'd6, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_busy_busy", {31'd0, busy}, 32'd0);
    repeat (DW + 4) @(posedge clk);
    #1;
    chk("flush_busy_no_pulse", {31'd0, out_valid}, 32'd0);
    issue(5'd0, 32'd2, 32'd3, 1'b1);
    @(posedge clk); #1;

    // Flush coincident with out_ready in DONE
    rdy_dir = 1'b0;
    issue(5'd0, 32'd1, 32'd1, 1'b1);
    wait_valid();
    flush = 1'b1; rdy_dir = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_done_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_done_no_pulse", {31'd0, out_valid}, 32'd0);
    issue(5'd0, 32'd2, 32'd3, 1'b1);

    // Randomized ops with random consumer backpressure
    rand_mode = 1'b1;
    repeat (80) issue(5'($urandom_range(0, 31)), pick(), pick(), 1'b1);
    rand_mode = 1'b0;

    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
